// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I core types; bimodal predictor counter enum and saturating update.
package rv32i_types;
   localparam int BP_IDX_BITS_DEFAULT = 6;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_ctr_t;
   function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
      return taken ? (c == ST ? ST : bp_ctr_t'(c + 2'd1)) : (c == SNT ? SNT : bp_ctr_t'(c - 2'd1));
   endfunction
endpackage

// File: rtl/bp_ctr_table.sv
// bp_ctr_table: 2-bit saturating counter array, async read, one trained write port, async reset.
module bp_ctr_table
   import rv32i_types::*;
#(
   parameter int IDX_BITS = BP_IDX_BITS_DEFAULT,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output bp_ctr_t             rd_ctr,
   input  logic                upd_en,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic                upd_taken
);
   bp_ctr_t ctr [2**IDX_BITS];
   assign rd_ctr = ctr[rd_idx];
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < 2**IDX_BITS; i++) ctr[i] <= bp_ctr_t'(INIT_CTR);
      else if (upd_en)
         ctr[upd_idx] <= bp_ctr_next(ctr[upd_idx], upd_taken);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor with registered mispredict flush/redirect.
// Define BP_PERF_CNT_EN to add perf_branches/perf_mispredicts counters.
module branch_predictor
   import rv32i_types::*;
#(
   parameter int IDX_BITS = BP_IDX_BITS_DEFAULT,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_br_en,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_target,
   output logic        flush,
   output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
`endif
);
   logic    resolve, mispredict, unused_pc;
   bp_ctr_t rd_ctr;
   assign resolve       = ex_valid & ~ex_stall & ex_is_branch;
   assign mispredict    = resolve & (ex_br_en != ex_pred_taken);
   assign if_pred_taken = rd_ctr[1];
   assign unused_pc     = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};
   bp_ctr_table #(.IDX_BITS(IDX_BITS), .INIT_CTR(INIT_CTR)) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (if_pc[IDX_BITS+1:2]),
      .rd_ctr    (rd_ctr),
      .upd_en    (resolve),
      .upd_idx   (ex_pc[IDX_BITS+1:2]),
      .upd_taken (ex_br_en)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         flush       <= 1'b0;
         redirect_pc <= 32'h0;
      end else begin
         flush <= mispredict;
         if (mispredict) redirect_pc <= ex_br_en ? ex_target : ex_pc + 32'd4;
      end
`ifdef BP_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         perf_branches    <= 32'h0;
         perf_mispredicts <= 32'h0;
      end else begin
         perf_branches    <= perf_branches + {31'h0, resolve};
         perf_mispredicts <= perf_mispredicts + {31'h0, mispredict};
      end
`endif
endmodule
